// File: rtl/itch_message_sequencer.sv
// Front-end controller of the ITCH parser: delimits length-prefixed messages from the
// 64-bit framer stream, starts and feeds the matching field parser, and keeps statistics.
module itch_message_sequencer #(
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  parser_start,
    output logic [63:0] parser_data,
    output logic        parser_valid,
    output logic [3:0]  parser_beat,
    input  logic [4:0]  parser_done,
    output logic [7:0]  msg_type,
    output logic [15:0] msg_length,
    output logic [31:0] msg_count,
    output logic [15:0] drop_count,
    output logic        err_len,
    output logic        err_timeout
);

    localparam int          WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DROP,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [4:0]         parser_start_q, parser_start_d;
    logic [63:0]        parser_data_q, parser_data_d;
    logic               parser_valid_q, parser_valid_d;
    logic [3:0]         parser_beat_q, parser_beat_d;
    logic [7:0]         msg_type_q, msg_type_d;
    logic [15:0]        msg_length_q, msg_length_d;
    logic [31:0]        msg_count_q, msg_count_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic               err_len_q, err_len_d;
    logic               err_timeout_q, err_timeout_d;
    logic [4:0]         sel_q, sel_d;
    logic [16:0]        beats_left_q, beats_left_d;
    logic               done_seen_q, done_seen_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic               accept;
    logic [15:0]        hdr_len;
    logic [7:0]         hdr_type;
    logic [4:0]         hdr_sel;
    logic [16:0]        beats_total;
    logic [16:0]        hdr_beats_left;
    logic               len_bad;
    logic               done_hit;
    logic [15:0]        drop_count_inc;

    function automatic logic [4:0] type_to_sel(input logic [7:0] t);
        logic [4:0] s;
        case (t)
            8'h41:   s = 5'b00001;
            8'h46:   s = 5'b00010;
            8'h45:   s = 5'b00100;
            8'h43:   s = 5'b01000;
            8'h44:   s = 5'b10000;
            default: s = 5'b00000;
        endcase
        return s;
    endfunction

    // Header decode is evaluated every cycle; it only matters on an IDLE accept.
    assign accept         = in_valid && in_ready_q;
    assign hdr_len        = in_data[15:0];
    assign hdr_type       = in_data[23:16];
    assign hdr_sel        = type_to_sel(hdr_type);
    assign beats_total    = ({1'b0, hdr_len} + 17'd9) >> 3;
    assign hdr_beats_left = beats_total - 17'd1;
    assign len_bad        = (hdr_len == 16'd0) || (hdr_len > MAX_LEN_W);
    assign done_hit       = |(parser_done & sel_q);
    assign drop_count_inc = (drop_count_q == 16'hFFFF) ? drop_count_q : drop_count_q + 16'd1;

    always_comb begin
        state_d        = state_q;
        parser_start_d = '0;
        parser_data_d  = parser_data_q;
        parser_valid_d = 1'b0;
        parser_beat_d  = parser_beat_q;
        msg_type_d     = msg_type_q;
        msg_length_d   = msg_length_q;
        msg_count_d    = msg_count_q;
        drop_count_d   = drop_count_q;
        err_len_d      = 1'b0;
        err_timeout_d  = 1'b0;
        sel_d          = sel_q;
        beats_left_d   = beats_left_q;
        done_seen_d    = done_seen_q;
        wait_cnt_d     = '0;

        case (state_q)
            IDLE: begin
                done_seen_d = 1'b0;
                if (accept) begin
                    msg_type_d   = hdr_type;
                    msg_length_d = hdr_len;
                    beats_left_d = hdr_beats_left;
                    if (len_bad) begin
                        err_len_d    = 1'b1;
                        drop_count_d = drop_count_inc;
                        beats_left_d = '0;
                    end else if (hdr_sel == 5'b00000) begin
                        drop_count_d = drop_count_inc;
                        state_d      = (hdr_beats_left != 17'd0) ? DROP : IDLE;
                    end else begin
                        sel_d          = hdr_sel;
                        parser_start_d = hdr_sel;
                        parser_valid_d = 1'b1;
                        parser_beat_d  = 4'd0;
                        parser_data_d  = in_data;
                        state_d        = (hdr_beats_left != 17'd0) ? STREAM : WAIT_DONE;
                    end
                end
            end

            STREAM: begin
                // A parser may finish before its last beat; remember it for WAIT_DONE.
                if (done_hit) begin
                    done_seen_d = 1'b1;
                end
                if (accept) begin
                    parser_valid_d = 1'b1;
                    parser_data_d  = in_data;
                    parser_beat_d  = parser_beat_q + 4'd1;
                    beats_left_d   = beats_left_q - 17'd1;
                    if (beats_left_q == 17'd1) begin
                        state_d = WAIT_DONE;
                    end
                end
            end

            DROP: begin
                if (accept) begin
                    beats_left_d = beats_left_q - 17'd1;
                    if (beats_left_q == 17'd1) begin
                        state_d = IDLE;
                    end
                end
            end

            WAIT_DONE: begin
                if (done_hit || done_seen_q) begin
                    msg_count_d = msg_count_q + 32'd1;
                    done_seen_d = 1'b0;
                    state_d     = IDLE;
                end else if (wait_cnt_q + 1'b1 == TIMEOUT_W) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d != WAIT_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            parser_start_q <= '0;
            parser_data_q  <= '0;
            parser_valid_q <= 1'b0;
            parser_beat_q  <= '0;
            msg_type_q     <= '0;
            msg_length_q   <= '0;
            msg_count_q    <= '0;
            drop_count_q   <= '0;
            err_len_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            sel_q          <= '0;
            beats_left_q   <= '0;
            done_seen_q    <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            parser_start_q <= parser_start_d;
            parser_data_q  <= parser_data_d;
            parser_valid_q <= parser_valid_d;
            parser_beat_q  <= parser_beat_d;
            msg_type_q     <= msg_type_d;
            msg_length_q   <= msg_length_d;
            msg_count_q    <= msg_count_d;
            drop_count_q   <= drop_count_d;
            err_len_q      <= err_len_d;
            err_timeout_q  <= err_timeout_d;
            sel_q          <= sel_d;
            beats_left_q   <= beats_left_d;
            done_seen_q    <= done_seen_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign parser_start = parser_start_q;
    assign parser_data  = parser_data_q;
    assign parser_valid = parser_valid_q;
    assign parser_beat  = parser_beat_q;
    assign msg_type     = msg_type_q;
    assign msg_length   = msg_length_q;
    assign msg_count    = msg_count_q;
    assign drop_count   = drop_count_q;
    assign err_len      = err_len_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_itch_message_sequencer.sv
// Directed bench for itch_message_sequencer; forwarded beats are checked against a
// scoreboard queue filled as each beat is driven.
module tb_itch_message_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  parser_start;
    logic [63:0] parser_data;
    logic        parser_valid;
    logic [3:0]  parser_beat;
    logic [4:0]  parser_done;
    logic [7:0]  msg_type;
    logic [15:0] msg_length;
    logic [31:0] msg_count;
    logic [15:0] drop_count;
    logic        err_len;
    logic        err_timeout;

    typedef struct packed {
        logic [4:0]  start;
        logic [3:0]  beat;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_msgs = 0;
    int   exp_drops = 0;
    int   wait_n;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    itch_message_sequencer #(.MAX_LEN(64), .TIMEOUT(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .parser_start (parser_start),
        .parser_data  (parser_data),
        .parser_valid (parser_valid),
        .parser_beat  (parser_beat),
        .parser_done  (parser_done),
        .msg_type     (msg_type),
        .msg_length   (msg_length),
        .msg_count    (msg_count),
        .drop_count   (drop_count),
        .err_len      (err_len),
        .err_timeout  (err_timeout)
    );

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ctrl"},
                     {in_ready, parser_start, parser_valid, err_len, err_timeout, parser_beat}, '0);
        check_output({tag, "_data"}, parser_data, '0);
        check_output({tag, "_hdr"}, {msg_type, msg_length}, '0);
        check_output({tag, "_msg_count"}, msg_count, '0);
        check_output({tag, "_drop_count"}, drop_count, '0);
    endtask

    // Drive one beat, optionally expecting it forwarded; returns #1 after its transfer edge.
    task automatic apply_stimulus(input logic [63:0] d, input bit fwd,
                                  input logic [4:0] st, input logic [3:0] bt);
        int guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        if (fwd) sb.push_back('{start: st, beat: bt, data: d});
        while (in_ready !== 1'b1 && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) check_output("in_ready_wait", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Scoreboard monitor: every forwarded beat must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (parser_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_beat", 128'(parser_valid), 128'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check_output("beat_start", 128'(parser_start), 128'(mon_e.start));
                    check_output("beat_index", 128'(parser_beat), 128'(mon_e.beat));
                    check_output("beat_data", 128'(parser_data), 128'(mon_e.data));
                end
            end else if (parser_start !== 5'b00000) begin
                check_output("stray_start", 128'(parser_start), 128'(0));
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        parser_done = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("reset");
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A: 36 bytes -> header plus four beats, done two cycles after the last beat
        apply_stimulus({40'hAB_CDEF_0123, 8'h41, 16'd36}, 1, 5'b00001, 4'd0);
        for (int i = 1; i <= 4; i++)
            apply_stimulus(64'hC0DE_A000_0000_0000 | 64'(i), 1, 5'b00000, 4'(i));
        @(negedge clk);
        check_output("a_ready_low_1", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        parser_done = 5'b00001;
        @(negedge clk);
        check_output("a_ready_low_2", 128'(in_ready), 128'(0));
        check_output("a_count_before", 128'(msg_count), 128'(0));
        @(posedge clk);
        #1;
        parser_done = 5'b00000;
        @(negedge clk);
        exp_msgs = 1;
        check_output("a_msg_count", 128'(msg_count), 128'(exp_msgs));
        check_output("a_ready_back", 128'(in_ready), 128'(1));
        check_output("a_hdr", {msg_type, msg_length}, {8'h41, 16'd36});
        check_output("a_sb_empty", 128'(sb.size()), 128'(0));

        // D: 19 bytes -> three beats with a one-cycle valid gap
        apply_stimulus({40'h11_2233_4455, 8'h44, 16'd19}, 1, 5'b10000, 4'd0);
        apply_stimulus(64'hD00D_0000_0000_0001, 1, 5'b00000, 4'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("d_bubble", 128'(parser_valid), 128'(0));
        apply_stimulus(64'hD00D_0000_0000_0002, 1, 5'b00000, 4'd2);
        parser_done = 5'b10000;
        @(posedge clk);
        #1;
        parser_done = 5'b00000;
        @(negedge clk);
        exp_msgs++;
        check_output("d_msg_count", 128'(msg_count), 128'(exp_msgs));

        // Unknown type 0x58, 20 bytes -> three beats consumed silently
        apply_stimulus({40'h99_8877_6655, 8'h58, 16'd20}, 0, 5'b00000, 4'd0);
        apply_stimulus(64'hBAD0_0000_0000_0001, 0, 5'b00000, 4'd0);
        apply_stimulus(64'hBAD0_0000_0000_0002, 0, 5'b00000, 4'd0);
        @(negedge clk);
        exp_drops++;
        check_output("unk_drop_count", 128'(drop_count), 128'(exp_drops));
        check_output("unk_hdr", {msg_type, msg_length}, {8'h58, 16'd20});
        check_output("unk_ready", 128'(in_ready), 128'(1));

        // A, 12 bytes -> two beats; done arrives during the stream and must stick
        apply_stimulus({40'h55_6677_8899, 8'h41, 16'd12}, 1, 5'b00001, 4'd0);
        parser_done = 5'b00001;
        apply_stimulus(64'hA2A2_0000_0000_0001, 1, 5'b00000, 4'd1);
        parser_done = 5'b00000;
        @(negedge clk);
        check_output("sticky_wait_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        exp_msgs++;
        check_output("sticky_msg_count", 128'(msg_count), 128'(exp_msgs));
        check_output("sticky_ready", 128'(in_ready), 128'(1));

        // Illegal lengths 0 and 65
        apply_stimulus({40'h0, 8'h41, 16'd0}, 0, 5'b00000, 4'd0);
        @(negedge clk);
        exp_drops++;
        check_output("len0_err", 128'(err_len), 128'(1));
        check_output("len0_drop", 128'(drop_count), 128'(exp_drops));
        @(negedge clk);
        check_output("len0_pulse_end", {err_len, in_ready}, {1'b0, 1'b1});
        apply_stimulus({40'h0, 8'h44, 16'd65}, 0, 5'b00000, 4'd0);
        @(negedge clk);
        exp_drops++;
        check_output("len65_err", 128'(err_len), 128'(1));
        check_output("len65_drop", 128'(drop_count), 128'(exp_drops));
        check_output("len65_hdr", {msg_type, msg_length}, {8'h44, 16'd65});
        @(negedge clk);
        check_output("len65_pulse_end", {err_len, in_ready}, {1'b0, 1'b1});

        // E, 31 bytes -> five beats; only a wrong-parser done is offered
        apply_stimulus({40'hEE_0000_1111, 8'h45, 16'd31}, 1, 5'b00100, 4'd0);
        for (int i = 1; i <= 4; i++)
            apply_stimulus(64'hE0E0_0000_0000_0000 | 64'(i), 1, 5'b00000, 4'(i));
        parser_done = 5'b00001;
        wait_n = 0;
        while (wait_n < 400) begin
            @(negedge clk);
            wait_n++;
            if (err_timeout === 1'b1) break;
        end
        check_output("timeout_wait_cycles", 128'(wait_n - 1), 128'(255));
        check_output("timeout_msg_count", 128'(msg_count), 128'(exp_msgs));
        parser_done = 5'b00000;
        @(negedge clk);
        check_output("timeout_pulse_end", {err_timeout, in_ready}, {1'b0, 1'b1});

        // C, 40 bytes; reset lands in the middle of the stream
        apply_stimulus({40'hCC_0000_2222, 8'h43, 16'd40}, 1, 5'b01000, 4'd0);
        apply_stimulus(64'hC3C3_0000_0000_0001, 1, 5'b00000, 4'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("mid_reset");
        exp_msgs  = 0;
        exp_drops = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // F, 6 bytes -> header only
        apply_stimulus({40'hFF_0000_3333, 8'h46, 16'd6}, 1, 5'b00010, 4'd0);
        parser_done = 5'b00010;
        @(posedge clk);
        #1;
        parser_done = 5'b00000;
        @(negedge clk);
        exp_msgs++;
        check_output("f_msg_count", 128'(msg_count), 128'(exp_msgs));
        check_output("f_drop_count", 128'(drop_count), 128'(exp_drops));
        check_output("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
